// File: rtl/commit_arbiter_pkg.sv
// rtl/commit_arbiter_pkg.sv - shared types and port map for the commit arbiter
// Optional FPU result port enabled by defining APOGEO_FPU_PORT_EN.
package commit_arbiter_pkg;

  localparam int ITU_CSR_PORT = 0;
  localparam int LSU_PORT     = 1;
  localparam int FPU_PORT     = 2;

`ifdef APOGEO_FPU_PORT_EN
  localparam int ARB_PORTS = 3;
`else
  localparam int ARB_PORTS = 2;
`endif

  typedef logic [31:0] data_word_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [5:0]  rob_tag;
    logic        exception_generated;
    logic [3:0]  exception_code;
  } instr_packet_t;

  typedef struct packed {
    data_word_t    result;
    instr_packet_t ipacket;
  } arb_entry_t;

endpackage

// File: rtl/commit_arbiter_if.sv
// rtl/commit_arbiter_if.sv - execution-unit result ports and reorder-buffer write port
// Port count follows APOGEO_FPU_PORT_EN through the package.
interface commit_arbiter_if
  import commit_arbiter_pkg::*;
#(
  parameter int ARB_PORTS = commit_arbiter_pkg::ARB_PORTS
);

  logic                          flush_i;
  logic                          stall_i;
  data_word_t    [ARB_PORTS-1:0] result_i;
  instr_packet_t [ARB_PORTS-1:0] ipacket_i;
  logic          [ARB_PORTS-1:0] data_valid_i;
  logic          [ARB_PORTS-1:0] port_full_o;
  data_word_t                    rob_result_o;
  instr_packet_t                 rob_ipacket_o;
  logic                          rob_valid_o;
  logic                          idle_o;
  logic                          overflow_o;

  modport master (
    output flush_i, stall_i, result_i, ipacket_i, data_valid_i,
    input  port_full_o, rob_result_o, rob_ipacket_o, rob_valid_o, idle_o, overflow_o
  );

  modport slave (
    input  flush_i, stall_i, result_i, ipacket_i, data_valid_i,
    output port_full_o, rob_result_o, rob_ipacket_o, rob_valid_o, idle_o, overflow_o
  );

endinterface

// File: rtl/commit_arbiter_result_fifo.sv
// rtl/commit_arbiter_result_fifo.sv - per-port result FIFO with count, full and empty
// Caller guarantees push on full only together with a pop.
module result_fifo
  import commit_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  arb_entry_t       wdata,
  output arb_entry_t       rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  arb_entry_t    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage is not reset; pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (push && !rst && !flush) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/commit_arbiter.sv
// rtl/commit_arbiter.sv - round-robin merge of execution results into one reorder-buffer write
// Third (FPU) port present only when APOGEO_FPU_PORT_EN is defined.
module commit_arbiter
  import commit_arbiter_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int ARB_PORTS  = commit_arbiter_pkg::ARB_PORTS
) (
  input  logic           clk_i,
  input  logic           rst_i,
  commit_arbiter_if.slave bus
);

  localparam int PTR_W = (ARB_PORTS > 1) ? $clog2(ARB_PORTS) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  arb_entry_t           head [ARB_PORTS];
  logic [CNT_W-1:0]     count [ARB_PORTS];
  logic [ARB_PORTS-1:0] full;
  logic [ARB_PORTS-1:0] empty;
  logic [ARB_PORTS-1:0] push;
  logic [ARB_PORTS-1:0] pop;
  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant;
  logic [PTR_W-1:0]     next_rr;
  logic                 grant_valid;
  logic                 load;
  logic                 overflow_set;
  logic                 any_buffered;
  arb_entry_t           out_q;
  logic                 out_valid;
  logic                 overflow;

  for (genvar p = 0; p < ARB_PORTS; p++) begin : g_port
    arb_entry_t wdata;
    assign wdata = {bus.result_i[p], bus.ipacket_i[p]};

    result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk_i),
      .rst   (rst_i),
      .flush (bus.flush_i),
      .push  (push[p]),
      .pop   (pop[p]),
      .wdata (wdata),
      .rdata (head[p]),
      .count (count[p]),
      .full  (full[p]),
      .empty (empty[p])
    );

    assign pop[p]  = load && grant_valid && (grant == PTR_W'(p));
    assign push[p] = bus.data_valid_i[p] && (!full[p] || pop[p]);
  end

  assign load = !out_valid || !bus.stall_i;

  // Second pass overrides the wrap-around pick with the first port at or after rr_ptr.
  always_comb begin
    grant       = '0;
    grant_valid = 1'b0;
    for (int p = ARB_PORTS - 1; p >= 0; p--) begin
      if (!empty[p]) begin
        grant       = PTR_W'(p);
        grant_valid = 1'b1;
      end
    end
    for (int p = ARB_PORTS - 1; p >= 0; p--) begin
      if (!empty[p] && (PTR_W'(p) >= rr_ptr)) begin
        grant       = PTR_W'(p);
        grant_valid = 1'b1;
      end
    end
  end

  assign next_rr      = (grant == PTR_W'(ARB_PORTS - 1)) ? '0 : grant + PTR_W'(1);
  assign overflow_set = |(bus.data_valid_i & full & ~pop);

  always_comb begin
    any_buffered = 1'b0;
    for (int p = 0; p < ARB_PORTS; p++) begin
      any_buffered = any_buffered | (count[p] != '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      out_valid <= 1'b0;
      out_q     <= '0;
      rr_ptr    <= '0;
      overflow  <= 1'b0;
    end else begin
      if (overflow_set && !bus.flush_i) overflow <= 1'b1;
      if (bus.flush_i) begin
        out_valid <= 1'b0;
        rr_ptr    <= '0;
      end else if (load) begin
        out_valid <= grant_valid;
        if (grant_valid) begin
          out_q  <= head[grant];
          rr_ptr <= next_rr;
        end
      end
    end
  end

  assign bus.rob_result_o  = out_q.result;
  assign bus.rob_ipacket_o = out_q.ipacket;
  assign bus.rob_valid_o   = out_valid;
  assign bus.port_full_o   = full;
  assign bus.overflow_o    = overflow;
  assign bus.idle_o        = !out_valid && !any_buffered;

endmodule

// File: tb/tb_commit_arbiter.sv
// tb/tb_commit_arbiter.sv - scoreboard bench for commit_arbiter against a queue-based model
module tb_commit_arbiter;
  import commit_arbiter_pkg::*;

  localparam int DEPTH = 4;
  localparam int N     = ARB_PORTS;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  commit_arbiter_if bus ();

  commit_arbiter #(.FIFO_DEPTH(DEPTH), .ARB_PORTS(N)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;
  bit mon_en = 1'b0;

  arb_entry_t mq [N][$];
  arb_entry_t exp_q [$];
  int         mrr   = 0;
  bit         mvalid = 1'b0;
  bit         movf   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: per-port queues, round-robin pick by modular search.
  always @(posedge clk) begin : model
    int g;
    int pp;
    if (rst || bus.flush_i) begin
      for (int p = 0; p < N; p++) mq[p].delete();
      exp_q.delete();
      mvalid = 1'b0;
      mrr    = 0;
      if (rst) movf = 1'b0;
    end else begin
      if (!mvalid || !bus.stall_i) begin
        g = -1;
        for (int k = 0; k < N; k++) begin
          pp = (mrr + k) % N;
          if (g < 0 && mq[pp].size() > 0) g = pp;
        end
        if (g >= 0) begin
          exp_q.push_back(mq[g].pop_front());
          mvalid = 1'b1;
          mrr    = (g + 1) % N;
        end else begin
          mvalid = 1'b0;
        end
      end
      for (int p = 0; p < N; p++) begin
        if (bus.data_valid_i[p]) begin
          if (mq[p].size() < DEPTH) mq[p].push_back({bus.result_i[p], bus.ipacket_i[p]});
          else movf = 1'b1;
        end
      end
    end
  end

  always @(negedge clk) begin : monitor
    logic [N-1:0] fexp;
    bit           empty_all;
    if (mon_en) begin
      empty_all = 1'b1;
      for (int p = 0; p < N; p++) begin
        fexp[p] = (mq[p].size() == DEPTH);
        if (mq[p].size() != 0) empty_all = 1'b0;
      end
      check("rob_valid", bus.rob_valid_o, mvalid);
      check("port_full", bus.port_full_o, fexp);
      check("overflow", bus.overflow_o, movf);
      check("idle", bus.idle_o, !mvalid && empty_all);
      if (mvalid && exp_q.size() > 0) begin
        check("rob_data", {bus.rob_result_o, bus.rob_ipacket_o}, exp_q[0]);
        if (!bus.stall_i && !bus.flush_i && !rst) void'(exp_q.pop_front());
      end
    end
  end

  function automatic instr_packet_t rand_pkt();
    instr_packet_t k;
    k.pc                  = $urandom;
    k.rd                  = 5'($urandom);
    k.rob_tag             = 6'($urandom);
    k.exception_generated = 1'($urandom);
    k.exception_code      = 4'($urandom);
    return k;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_port(input int p, input data_word_t d);
    bus.data_valid_i[p] = 1'b1;
    bus.result_i[p]     = d;
    bus.ipacket_i[p]    = rand_pkt();
  endtask

  task automatic clear_ports();
    bus.data_valid_i = '0;
  endtask

  task automatic check_reset_values();
    check("rst_valid", bus.rob_valid_o, 1'b0);
    check("rst_result", bus.rob_result_o, 32'h0);
    check("rst_ipacket", bus.rob_ipacket_o, '0);
    check("rst_overflow", bus.overflow_o, 1'b0);
    check("rst_full", bus.port_full_o, '0);
    check("rst_idle", bus.idle_o, 1'b1);
  endtask

  initial begin
    rst              = 1'b1;
    bus.flush_i      = 1'b0;
    bus.stall_i      = 1'b0;
    bus.data_valid_i = '0;
    bus.result_i     = '0;
    bus.ipacket_i    = '0;
    @(posedge clk);
    mon_en = 1'b1;
    #1;
    step();
    rst = 1'b0;
    check_reset_values();

    // Single result latency
    set_port(ITU_CSR_PORT, 32'h0000_00AA);
    step();
    clear_ports();
    step();
    check("single_valid", bus.rob_valid_o, 1'b1);
    check("single_data", bus.rob_result_o, 32'h0000_00AA);
    step();
    check("single_idle", bus.idle_o, 1'b1);

    // Simultaneous push on all ports from rr_ptr 0
    bus.flush_i = 1'b1;
    step();
    bus.flush_i = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, data_word_t'(p + 1));
    step();
    clear_ports();
    for (int k = 0; k < N; k++) begin
      step();
      check("rr_order", bus.rob_result_o, data_word_t'(k + 1));
    end
    step();
    check("rr_idle", bus.idle_o, 1'b1);

    // Stalled output while port 1 overflows
    set_port(ITU_CSR_PORT, 32'h0000_0C0D);
    step();
    clear_ports();
    bus.stall_i = 1'b1;
    step();
    for (int i = 0; i < 5; i++) begin
      set_port(LSU_PORT, data_word_t'(100 + i));
      step();
      check("stall_full", bus.port_full_o[LSU_PORT], (i >= 3));
      check("stall_ovf", bus.overflow_o, (i == 4));
      check("stall_hold", bus.rob_result_o, 32'h0000_0C0D);
    end
    clear_ports();
    for (int i = 0; i < 4; i++) begin
      step();
      check("stall_hold2", bus.rob_result_o, 32'h0000_0C0D);
    end
    bus.stall_i = 1'b0;
    repeat (7) step();
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Full port with same-cycle pop and push
    bus.stall_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_port(ITU_CSR_PORT, data_word_t'(200 + i));
      step();
    end
    check("fill_full", bus.port_full_o[ITU_CSR_PORT], 1'b1);
    bus.stall_i = 1'b0;
    set_port(ITU_CSR_PORT, 32'd205);
    step();
    clear_ports();
    check("poppush_full", bus.port_full_o[ITU_CSR_PORT], 1'b1);
    check("poppush_ovf", bus.overflow_o, 1'b0);
    repeat (7) step();

    // Flush with buffered entries and a same-cycle push
    bus.stall_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_port(LSU_PORT, data_word_t'(300 + i));
      step();
    end
    bus.flush_i = 1'b1;
    set_port(LSU_PORT, 32'd399);
    step();
    bus.flush_i = 1'b0;
    clear_ports();
    check("flush_idle", bus.idle_o, 1'b1);
    check("flush_valid", bus.rob_valid_o, 1'b0);
    bus.stall_i = 1'b0;
    for (int p = 0; p < N; p++) set_port(p, data_word_t'(400 + p));
    step();
    clear_ports();
    step();
    check("flush_rr0", bus.rob_result_o, 32'd400);
    repeat (5) step();

    // Reset mid-stream
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < N; p++) set_port(p, $urandom);
      bus.stall_i = (i == 1);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    clear_ports();
    bus.stall_i = 1'b0;
    check_reset_values();

    // Randomized traffic
    for (int c = 0; c < 3000; c++) begin
      for (int p = 0; p < N; p++) begin
        if ($urandom_range(99) < 45) set_port(p, $urandom);
        else bus.data_valid_i[p] = 1'b0;
      end
      bus.stall_i = ($urandom_range(99) < 30);
      bus.flush_i = ($urandom_range(99) < 2);
      rst         = ($urandom_range(999) < 4);
      step();
    end
    rst = 1'b0;
    bus.flush_i = 1'b0;
    bus.stall_i = 1'b0;
    clear_ports();
    repeat (3 * DEPTH + 4) step();
    check("final_idle", bus.idle_o, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/commit_arbiter.md
COMMIT_ARBITER -- requirements
Module: commit_arbiter

Interface
REQ-001 Parameter FIFO_DEPTH, default 4: entries per result-port FIFO; power of two, minimum 2.
REQ-002 Parameter ARB_PORTS, default 3 with APOGEO_FPU_PORT_EN and 2 without: number of execution-unit result ports.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk_i  in  1  clock; all state updates on rising edge.
REQ-005 rst_i  in  1  synchronous active-high reset.
REQ-006 flush_i  in  1  pipeline flush; discards all buffered results.
REQ-007 stall_i  in  1  reorder buffer cannot accept a write this cycle.
REQ-008 result_i  in  ARB_PORTS x data_word_t  per-port execution results.
REQ-009 ipacket_i  in  ARB_PORTS x instr_packet_t  per-port instruction packets.
REQ-010 data_valid_i  in  ARB_PORTS  per-port result valid.
REQ-011 port_full_o  out  ARB_PORTS  per-port FIFO full, used by the scheduler to hold issue.
REQ-012 rob_result_o  out  data_word_t  result presented to the reorder buffer.
REQ-013 rob_ipacket_o  out  instr_packet_t  packet presented to the reorder buffer.
REQ-014 rob_valid_o  out  1  rob_result_o/rob_ipacket_o valid.
REQ-015 idle_o  out  1  all FIFOs empty and rob_valid_o low.
REQ-016 overflow_o  out  1  sticky: a valid result was dropped on a full port.

Function
REQ-017 Each port has a FIFO_DEPTH FIFO; a push occurs on data_valid_i[p] when count < FIFO_DEPTH or when a pop of port p occurs in the same cycle.
REQ-018 A valid input on a full port with no same-cycle pop is dropped and sets overflow_o; overflow_o clears only on reset.
REQ-019 port_full_o[p] is combinational from count only: high when count == FIFO_DEPTH.
REQ-020 The output register loads when rob_valid_o is low, or when rob_valid_o is high and stall_i is low; a transfer is rob_valid_o & !stall_i.
REQ-021 On load, the grant goes round-robin to the first non-empty port at or after pointer rr_ptr; that head is popped into the output register.
REQ-022 After a grant to port g, rr_ptr becomes (g+1) mod ARB_PORTS; rr_ptr is unchanged when there is no grant.
REQ-023 When no FIFO is non-empty at load time, rob_valid_o goes low.
REQ-024 While stall_i is high and rob_valid_o is high, the outputs hold stable and no pop occurs.
REQ-025 Latency: a result pushed at edge N into an empty system, with stall_i low, appears with rob_valid_o high after edge N+1 (2 cycles from data_valid_i assertion); sustained throughput is 1 result per cycle.
REQ-026 Per-port ordering is preserved; there is no ordering guarantee across ports.
REQ-027 Packets with exception_generated set are arbitrated identically and passed unmodified.
REQ-028 flush_i empties all FIFOs, clears rob_valid_o and sets rr_ptr to 0 at the next edge, and dominates any same-cycle push or pop.

Reset
REQ-029 At rst_i, next edge: all FIFO counts and pointers 0; rr_ptr 0; rob_valid_o 0; rob_result_o '0; rob_ipacket_o '0; overflow_o 0; port_full_o all 0; idle_o 1.
REQ-030 rst_i asserted mid-transfer discards all content, with no partial write visible afterwards.

Configuration
REQ-031 Macro APOGEO_FPU_PORT_EN: when defined, ARB_PORTS = 3 and port 2 (FPU) is arbitrated.
REQ-032 When APOGEO_FPU_PORT_EN is undefined, ARB_PORTS = 2 and no port-2 logic or ports exist.

Structure
REQ-033 The shared package holds the constants ITU_CSR_PORT = 0, LSU_PORT = 1, FPU_PORT = 2, and the ARB_PORTS derivation.
REQ-034 One sub-module, result_fifo (single-port synchronous FIFO with count, full and empty), is instantiated per port.

Verification
REQ-035 Single ITU result 0x0000_00AA on port 0, stall_i low -> rob_valid_o high 2 cycles later with 0x0000_00AA; idle_o high the following cycle.
REQ-036 Ports 0, 1 and 2 valid in the same cycle with 0x1, 0x2, 0x3 and rr_ptr = 0 -> outputs 0x1, 0x2, 0x3 on consecutive cycles; rr_ptr ends at 0.
REQ-037 stall_i high for 10 cycles while port 1 pushes 5 results with FIFO_DEPTH = 4 -> port_full_o[1] goes high after 4 pushes, the 5th is dropped, overflow_o = 1, and the held output is stable for all stalled cycles.
REQ-038 Full port 0 with a same-cycle pop and push -> push accepted, count stays 4, overflow_o stays 0.
REQ-039 flush_i asserted with 3 entries buffered and a same-cycle push -> next cycle idle_o = 1, rob_valid_o = 0, rr_ptr = 0.
REQ-040 rst_i asserted mid-stream -> all outputs at their reset values one edge later; the build without APOGEO_FPU_PORT_EN passes REQ-035 to REQ-039 using ports 0 and 1 only.
